// File: rtl/reg_bus_sched.sv
// reg_bus_sched: owns the single PWM register-file port.
// After reset it replays a table of default register writes, then shares the
// port between the SPI decoder (m0, never stalled) and a local requester
// (m1, req/ack handshake).
//
// Handshake summary:
//   m0: m0_read/m0_write are single-cycle pulses. The access appears on the
//       bus in the same cycle and always wins. When both are high the write
//       is issued and the read is dropped.
//   m1: m1_req is held, with m1_we/m1_addr/m1_wdata stable, until m1_ack.
//       The grant is the cycle where the m1 access is on the bus.
//       m1_ack pulses for one cycle right after the grant.
//       m1_rdata holds the value captured on a read grant until the next ack.
//       No grant is given in the ack cycle.
module reg_bus_sched #(
   parameter int INIT_LEN = 4,
   parameter logic [((INIT_LEN > 0) ? INIT_LEN : 1)*6-1:0] INIT_ADDRS = '0,
   parameter logic [((INIT_LEN > 0) ? INIT_LEN : 1)*8-1:0] INIT_DATA  = '0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m0_read,
   input  logic       m0_write,
   input  logic [5:0] m0_addr,
   input  logic [7:0] m0_wdata,
   output logic [7:0] m0_rdata,
   input  logic       m1_req,
   input  logic       m1_we,
   input  logic [5:0] m1_addr,
   input  logic [7:0] m1_wdata,
   output logic       m1_ack,
   output logic [7:0] m1_rdata,
   output logic       read,
   output logic       write,
   output logic [5:0] addr,
   output logic [7:0] data_write,
   input  logic [7:0] data_read,
   output logic       init_done,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_M1_ACK = 2'd2
   } state_t;

   // idx must be able to hold INIT_LEN itself.
   localparam int IDX_W = (INIT_LEN < 2) ? 1 : $clog2(INIT_LEN + 1);
   localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(INIT_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((INIT_LEN > 0) ? INIT_LEN - 1 : 0);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             m0_act;
   logic             tbl_pending;
   logic             m1_grant;
   logic [5:0]       tbl_addr;
   logic [7:0]       tbl_data;

   assign m0_act      = m0_read | m0_write;
   assign tbl_pending = (state == ST_INIT) && (idx < LEN_IDX);
   assign m1_grant    = (state == ST_RUN) && m1_req && !m0_act;
   assign m0_rdata    = data_read;
   assign dbg_state   = state;

   // Select the current boot-table entry; a loop keeps indexing in range.
   always_comb begin
      tbl_addr = '0;
      tbl_data = '0;
      for (int i = 0; i < INIT_LEN; i++) begin
         if (idx == IDX_W'(i)) begin
            tbl_addr = INIT_ADDRS[i*6 +: 6];
            tbl_data = INIT_DATA[i*8 +: 8];
         end
      end
   end

   // Bus mux: m0 first, then the boot table, then an m1 grant; idle drives 0.
   always_comb begin
      read       = 1'b0;
      write      = 1'b0;
      addr       = '0;
      data_write = '0;
      if (rst) begin
         // Keep the register file untouched while reset is asserted.
         read = 1'b0;
      end else if (m0_act) begin
         write      = m0_write;
         read       = m0_read & ~m0_write;
         addr       = m0_addr;
         data_write = m0_wdata;
      end else if (tbl_pending) begin
         write      = 1'b1;
         addr       = tbl_addr;
         data_write = tbl_data;
      end else if (m1_grant) begin
         write      = m1_we;
         read       = ~m1_we;
         addr       = m1_addr;
         data_write = m1_wdata;
      end
   end

   // Scheduler FSM with registered init_done, m1_ack and m1_rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_INIT;
         idx       <= '0;
         init_done <= 1'b0;
         m1_ack    <= 1'b0;
         m1_rdata  <= '0;
      end else begin
         m1_ack <= 1'b0;
         case (state)
            ST_INIT: begin
               if (INIT_LEN == 0) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end else if (!m0_act) begin
                  // The table entry went out this cycle.
                  idx <= idx + 1'b1;
                  if (idx == LAST_IDX) begin
                     state     <= ST_RUN;
                     init_done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (m1_grant) begin
                  state  <= ST_M1_ACK;
                  m1_ack <= 1'b1;
                  if (!m1_we) begin
                     m1_rdata <= data_read;
                  end
               end
            end
            ST_M1_ACK: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

   // The register port never sees a read and a write together.
   assert property (@(posedge clk) disable iff (rst) !(read && write));

   // An ack is only ever presented from the ack state.
   assert property (@(posedge clk) disable iff (rst) m1_ack |-> (state == ST_M1_ACK));

endmodule

// File: tb/tb_reg_bus_sched.sv
// Bench for reg_bus_sched: directed per-cycle vector table, two hand-written
// reset sequences, then randomized traffic against a queue-based model.
module tb_reg_bus_sched;

   logic       clk;
   logic       rst;
   logic       m0_read;
   logic       m0_write;
   logic [5:0] m0_addr;
   logic [7:0] m0_wdata;
   logic [7:0] m0_rdata;
   logic       m1_req;
   logic       m1_we;
   logic [5:0] m1_addr;
   logic [7:0] m1_wdata;
   logic       m1_ack;
   logic [7:0] m1_rdata;
   logic       read;
   logic       write;
   logic [5:0] addr;
   logic [7:0] data_write;
   logic [7:0] data_read;
   logic       init_done;
   logic [1:0] dbg_state;

   reg_bus_sched #(
      .INIT_LEN   (3),
      .INIT_ADDRS ({6'h08, 6'h02, 6'h00}),
      .INIT_DATA  ({8'h80, 8'h10, 8'h01})
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_read    (m0_read),
      .m0_write   (m0_write),
      .m0_addr    (m0_addr),
      .m0_wdata   (m0_wdata),
      .m0_rdata   (m0_rdata),
      .m1_req     (m1_req),
      .m1_we      (m1_we),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_ack     (m1_ack),
      .m1_rdata   (m1_rdata),
      .read       (read),
      .write      (write),
      .addr       (addr),
      .data_write (data_write),
      .data_read  (data_read),
      .init_done  (init_done),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic       rst, m0r, m0w;
      logic [5:0] m0a;
      logic [7:0] m0d;
      logic       req, we;
      logic [5:0] m1a;
      logic [7:0] m1d, dr;
      logic       erd, ewr;
      logic [5:0] ea;
      logic [7:0] edw;
      logic       eack;
      logic [7:0] em1rd;
      logic       edone;
   } vec_t;

   function automatic vec_t mk(logic r, logic m0r, logic m0w, logic [5:0] m0a, logic [7:0] m0d,
                               logic req, logic we, logic [5:0] m1a, logic [7:0] m1d, logic [7:0] dr,
                               logic erd, logic ewr, logic [5:0] ea, logic [7:0] edw,
                               logic eack, logic [7:0] em1rd, logic edone);
      vec_t v;
      v.rst = r;   v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
      v.req = req; v.we = we;   v.m1a = m1a; v.m1d = m1d; v.dr = dr;
      v.erd = erd; v.ewr = ewr; v.ea = ea;   v.edw = edw;
      v.eack = eack; v.em1rd = em1rd; v.edone = edone;
      return v;
   endfunction

   vec_t vecs[$];
   vec_t v;

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic m0r, input logic m0w, input logic [5:0] m0a,
                        input logic [7:0] m0d, input logic req, input logic we,
                        input logic [5:0] m1a, input logic [7:0] m1d, input logic [7:0] dr);
      rst = r; m0_read = m0r; m0_write = m0w; m0_addr = m0a; m0_wdata = m0d;
      m1_req = req; m1_we = we; m1_addr = m1a; m1_wdata = m1d; data_read = dr;
   endtask

   // ---------------- reference model ----------------
   // Boot entries still to be written form a queue; the m1 side is described
   // by "is an ack due this cycle" and the last captured read value.
   typedef struct {
      logic [5:0] a;
      logic [7:0] d;
   } ent_t;

   ent_t       init_q[$];
   bit         m_done;
   bit         m_ack;
   logic [7:0] m_rdata;

   // Expected words: {read, write, addr, data_write, m1_ack, m1_rdata, init_done, m0_rdata}
   logic [33:0] exp_q[$];

   task automatic model_reset();
      ent_t e;
      init_q.delete();
      e.a = 6'h00; e.d = 8'h01; init_q.push_back(e);
      e.a = 6'h02; e.d = 8'h10; init_q.push_back(e);
      e.a = 6'h08; e.d = 8'h80; init_q.push_back(e);
      m_done  = 1'b0;
      m_ack   = 1'b0;
      m_rdata = 8'h00;
   endtask

   task automatic model_expect();
      logic       erd, ewr, eack, edone;
      logic [5:0] ea;
      logic [7:0] edw, erdata;
      erd = 0; ewr = 0; ea = 0; edw = 0;
      eack = m_ack; erdata = m_rdata; edone = m_done;
      if (rst) begin
         eack = 0; erdata = 0; edone = 0;
      end else if (m0_read || m0_write) begin
         ewr = m0_write; erd = m0_read && !m0_write; ea = m0_addr; edw = m0_wdata;
      end else if (!m_done && init_q.size() > 0) begin
         ewr = 1; ea = init_q[0].a; edw = init_q[0].d;
      end else if (m_done && !m_ack && m1_req) begin
         ewr = m1_we; erd = !m1_we; ea = m1_addr; edw = m1_wdata;
      end
      exp_q.push_back({erd, ewr, ea, edw, eack, erdata, edone, data_read});
   endtask

   task automatic model_edge();
      bit m0;
      bit grant;
      m0 = m0_read || m0_write;
      grant = 0;
      if (rst) begin
         model_reset();
      end else begin
         if (!m_done) begin
            if (!m0 && init_q.size() > 0) void'(init_q.pop_front());
            if (init_q.size() == 0) m_done = 1;
         end else if (!m_ack && m1_req && !m0) begin
            grant = 1;
            if (!m1_we) m_rdata = data_read;
         end
         m_ack = grant;
      end
   endtask

   task automatic scoreboard_check(input int c);
      logic [33:0] e;
      e = exp_q.pop_front();
      chk($sformatf("r%0d.read", c),       32'(read),       32'(e[33]));
      chk($sformatf("r%0d.write", c),      32'(write),      32'(e[32]));
      chk($sformatf("r%0d.addr", c),       32'(addr),       32'(e[31:26]));
      chk($sformatf("r%0d.data_write", c), 32'(data_write), 32'(e[25:18]));
      chk($sformatf("r%0d.m1_ack", c),     32'(m1_ack),     32'(e[17]));
      chk($sformatf("r%0d.m1_rdata", c),   32'(m1_rdata),   32'(e[16:9]));
      chk($sformatf("r%0d.init_done", c),  32'(init_done),  32'(e[8]));
      chk($sformatf("r%0d.m0_rdata", c),   32'(m0_rdata),   32'(e[7:0]));
   endtask

   bit         req_busy;
   bit         saw_ack;
   int         r;
   logic [5:0] ra;
   logic [7:0] rd8;

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      //          rst m0r m0w m0a    m0d    req we m1a    m1d    dr     | rd wr addr  dw    ack m1rd   done
      // Boot, no traffic.
      vecs.push_back(mk(1, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 0, 8'h00, 0)); // 0
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 1, 6'h00, 8'h01, 0, 8'h00, 0)); // 1
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 1, 6'h02, 8'h10, 0, 8'h00, 0)); // 2
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 1, 6'h08, 8'h80, 0, 8'h00, 0)); // 3
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 0, 8'h00, 1)); // 4
      // m1 read of 0x05 returning 0xA5.
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 0, 6'h05, 8'h00, 8'hA5,  1, 0, 6'h05, 8'h00, 0, 8'h00, 1)); // 5
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 0, 6'h05, 8'h00, 8'h11,  0, 0, 6'h00, 8'h00, 1, 8'hA5, 1)); // 6
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h22,  0, 0, 6'h00, 8'h00, 0, 8'hA5, 1)); // 7
      // m0 read of 0x01 contends with m1 write of 0x3C to 0x04.
      vecs.push_back(mk(0, 1, 0, 6'h01, 8'h00, 1, 1, 6'h04, 8'h3C, 8'h77,  1, 0, 6'h01, 8'h00, 0, 8'hA5, 1)); // 8
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 1, 6'h04, 8'h3C, 8'h66,  0, 1, 6'h04, 8'h3C, 0, 8'hA5, 1)); // 9
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 1, 6'h04, 8'h3C, 8'h66,  0, 0, 6'h00, 8'h00, 1, 8'hA5, 1)); // 10
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 0, 8'hA5, 1)); // 11
      // Back-to-back m1 writes: grant every second cycle.
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 1, 6'h0A, 8'h11, 8'h00,  0, 1, 6'h0A, 8'h11, 0, 8'hA5, 1)); // 12
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 1, 6'h0A, 8'h11, 8'h00,  0, 0, 6'h00, 8'h00, 1, 8'hA5, 1)); // 13
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 1, 6'h0B, 8'h22, 8'h00,  0, 1, 6'h0B, 8'h22, 0, 8'hA5, 1)); // 14
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 1, 6'h0B, 8'h22, 8'h00,  0, 0, 6'h00, 8'h00, 1, 8'hA5, 1)); // 15
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 0, 8'hA5, 1)); // 16
      // m0 read and write together: write wins.
      vecs.push_back(mk(0, 1, 1, 6'h3F, 8'h5A, 0, 0, 6'h00, 8'h00, 8'h00,  0, 1, 6'h3F, 8'h5A, 0, 8'hA5, 1)); // 17
      // Reset masks an m0 pulse.
      vecs.push_back(mk(1, 0, 1, 6'h10, 8'hFF, 0, 0, 6'h00, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 0, 8'h00, 0)); // 18
      // Boot with an m0 write in the 2nd cycle and an m1 read waiting through INIT.
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 0, 6'h07, 8'h00, 8'h00,  0, 1, 6'h00, 8'h01, 0, 8'h00, 0)); // 19
      vecs.push_back(mk(0, 0, 1, 6'h03, 8'hC3, 1, 0, 6'h07, 8'h00, 8'h00,  0, 1, 6'h03, 8'hC3, 0, 8'h00, 0)); // 20
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 0, 6'h07, 8'h00, 8'h00,  0, 1, 6'h02, 8'h10, 0, 8'h00, 0)); // 21
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 0, 6'h07, 8'h00, 8'h00,  0, 1, 6'h08, 8'h80, 0, 8'h00, 0)); // 22
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 0, 6'h07, 8'h00, 8'h3C,  1, 0, 6'h07, 8'h00, 0, 8'h00, 1)); // 23
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 0, 6'h07, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 1, 8'h3C, 1)); // 24
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 0, 8'h3C, 1)); // 25
      // m1 request withdrawn before any grant: nothing issued, no ack, no hang.
      vecs.push_back(mk(0, 1, 0, 6'h02, 8'h00, 1, 0, 6'h09, 8'h00, 8'h44,  1, 0, 6'h02, 8'h00, 0, 8'h3C, 1)); // 26
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h09, 8'h00, 8'h44,  0, 0, 6'h00, 8'h00, 0, 8'h3C, 1)); // 27
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 0, 8'h3C, 1)); // 28
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 1, 6'h12, 8'h99, 8'h00,  0, 1, 6'h12, 8'h99, 0, 8'h3C, 1)); // 29
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 1, 1, 6'h12, 8'h99, 8'h00,  0, 0, 6'h00, 8'h00, 1, 8'h3C, 1)); // 30
      vecs.push_back(mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00,  0, 0, 6'h00, 8'h00, 0, 8'h3C, 1)); // 31

      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v.rst, v.m0r, v.m0w, v.m0a, v.m0d, v.req, v.we, v.m1a, v.m1d, v.dr);
         @(negedge clk);
         chk($sformatf("v%0d.read", i),       32'(read),       32'(v.erd));
         chk($sformatf("v%0d.write", i),      32'(write),      32'(v.ewr));
         chk($sformatf("v%0d.addr", i),       32'(addr),       32'(v.ea));
         chk($sformatf("v%0d.data_write", i), 32'(data_write), 32'(v.edw));
         chk($sformatf("v%0d.m1_ack", i),     32'(m1_ack),     32'(v.eack));
         chk($sformatf("v%0d.m1_rdata", i),   32'(m1_rdata),   32'(v.em1rd));
         chk($sformatf("v%0d.init_done", i),  32'(init_done),  32'(v.edone));
         chk($sformatf("v%0d.m0_rdata", i),   32'(m0_rdata),   32'(v.dr));
         @(posedge clk);
         #1;
      end

      // Reset asserted in the middle of an m1 read grant cycle.
      drive(0, 0, 0, 0, 0, 1, 0, 6'h05, 8'h00, 8'h5A);
      @(negedge clk);
      chk("rg.grant_read", 32'(read), 32'd1);
      chk("rg.grant_addr", 32'(addr), 32'h05);
      rst = 1'b1;
      #1;
      chk("rg.rst_read",       32'(read),       32'd0);
      chk("rg.rst_write",      32'(write),      32'd0);
      chk("rg.rst_addr",       32'(addr),       32'd0);
      chk("rg.rst_data_write", 32'(data_write), 32'd0);
      chk("rg.rst_init_done",  32'(init_done),  32'd0);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rg.no_ack",      32'(m1_ack),     32'd0);
      chk("rg.no_capture",  32'(m1_rdata),   32'd0);
      chk("rg.e0_write",    32'(write),      32'd1);
      chk("rg.e0_addr",     32'(addr),       32'h00);
      chk("rg.e0_data",     32'(data_write), 32'h01);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rg.e1_addr",     32'(addr),       32'h02);
      chk("rg.e1_data",     32'(data_write), 32'h10);
      @(posedge clk);
      #1;

      // Randomized traffic against the model, starting from a fresh reset.
      model_reset();
      req_busy = 0;
      saw_ack  = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c < 2) rst = 1'b1;
         else       rst = ($urandom_range(0, 99) == 0);

         r = $urandom_range(0, 9);
         m0_read  = (r < 2) || (r == 3);
         m0_write = (r == 2) || (r == 3);
         ra = 6'($urandom_range(0, 63));
         rd8 = 8'($urandom_range(0, 255));
         m0_addr  = ra;
         m0_wdata = rd8;

         // Requester: hold until ack, then release or start a new request.
         if (saw_ack) req_busy = 0;
         if (req_busy && $urandom_range(0, 59) == 0) req_busy = 0;
         if (!req_busy && $urandom_range(0, 2) == 0) begin
            req_busy = 1;
            m1_we    = 1'($urandom_range(0, 1));
            m1_addr  = 6'($urandom_range(0, 63));
            m1_wdata = 8'($urandom_range(0, 255));
         end
         m1_req    = req_busy;
         data_read = 8'($urandom_range(0, 255));

         @(negedge clk);
         model_expect();
         scoreboard_check(c);
         saw_ack = m1_ack;
         @(posedge clk);
         model_edge();
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_bus_sched.md
# reg_bus_sched

Register-bus scheduler between the SPI instruction decoder and the PWM register file. After reset it replays a parameterised table of default register writes, then shares the single register port between two masters. Master 0 is the decoder, with single-cycle pulses that are never stalled. Master 1 is a local requester (e.g. the counter/compare update engine) using a req/ack handshake.

## Interface
- INIT_LEN, 4: number of boot-time writes (0..63).
- INIT_ADDRS, 0: INIT_LEN×6-bit packed addresses; entry i at bits [6i+5:6i].
- INIT_DATA, 0: INIT_LEN×8-bit packed data; entry i at bits [8i+7:8i].
- clk  in  1  peripheral clock.
- rst  in  1  asynchronous, active-high reset.
- m0_read  in  1  decoder read pulse.
- m0_write  in  1  decoder write pulse.
- m0_addr  in  6  decoder address.
- m0_wdata  in  8  decoder write data.
- m0_rdata  out  8  read data to decoder; combinational copy of data_read.
- m1_req  in  1  local request; held until m1_ack.
- m1_we  in  1  1=write, 0=read; stable while m1_req.
- m1_addr  in  6  local address; stable while m1_req.
- m1_wdata  in  8  local write data; stable while m1_req.
- m1_ack  out  1  one-cycle completion pulse.
- m1_rdata  out  8  captured read data; valid in the m1_ack cycle and held until the next ack.
- read  out  1  register-file read strobe.
- write  out  1  register-file write strobe.
- addr  out  6  register-file address.
- data_write  out  8  register-file write data.
- data_read  in  8  register-file read data; combinational w.r.t. addr.
- init_done  out  1  high once the boot table has been written.

## Operation
- States: INIT, RUN, M1_ACK.
- INIT:
  - Each cycle, issue write=1 with addr=INIT_ADDRS[idx] and data_write=INIT_DATA[idx], unless m0 is active that cycle.
  - idx increments only on an issued write.
  - After entry INIT_LEN-1 is issued, go to RUN and set init_done=1 (registered).
  - INIT_LEN=0: go to RUN on the first clock after reset release.
- m0 priority, all states:
  - If m0_read or m0_write is high, the bus carries the m0 access in the same cycle, combinationally.
  - The table entry or m1 grant is deferred to a later cycle.
  - m0_write and m0_read both high: write issued, read suppressed.
- RUN:
  - m1_req=1 with no m0 activity → grant. Drive write=m1_we, read=~m1_we, addr=m1_addr, data_write=m1_wdata.
  - On a read grant, register data_read into m1_rdata.
  - Go to M1_ACK.
- M1_ACK:
  - m1_ack=1 for this one cycle; no m1 grant this cycle.
  - Return to RUN. m1 throughput is at most one access per 2 cycles.
- m1_req during INIT: waits, with no ack, until RUN.
- Idle bus (no access issued): read=0, write=0, addr=0, data_write=0.
- idx width is enough to count to INIT_LEN; idx does not wrap.

## Timing
- Reset values:
  - State INIT, idx=0, init_done=0, m1_ack=0, m1_rdata=0.
  - read=0, write=0, addr=0, data_write=0; bus outputs forced 0 while rst is high, including any m0 pulse.
  - m0_rdata follows data_read at all times.
- m0 latency: 0 cycles (pass-through).
- m1 latency: grant in cycle N when uncontended; ack in N+1.
  - Each contending m0 pulse adds one cycle.
  - m0 and m1_req arriving together: m0 served at N, m1 at N+1, ack at N+2.
- Init duration with no m0 traffic: INIT_LEN cycles; init_done rises in the cycle after the last table write.
- Reset mid-operation:
  - An outstanding m1 grant is abandoned with no ack; the requester must re-request.
  - Init restarts at entry 0.
- An m1_req dropped before ack (protocol violation) must not hang the FSM. If no grant has occurred, nothing is issued.

## Test plan
- Boot with INIT_LEN=3, table {0x00:0x01, 0x02:0x10, 0x08:0x80}, no traffic → three consecutive write pulses with those addr/data; init_done high at cycle 4 after reset release.
- m0_write to addr 0x03 in the 2nd INIT cycle → bus shows 0x03 that cycle; table entry 1 issued the next cycle; init_done one cycle later than baseline.
- RUN, m1 read of addr 0x05 with data_read=0xA5 → read=1, addr=0x05 in grant cycle; m1_ack and m1_rdata=0xA5 next cycle.
- m0_read of 0x01 and m1 write of 0x3C to 0x04 in the same cycle → m0 served first with m0_rdata=data_read; m1 write in the next cycle; ack the cycle after.
- Continuous m1_req writes → grants every 2nd cycle; ack never coincides with a grant.
- rst asserted in the m1 grant cycle → no ack, all outputs 0 immediately; after release, INIT replays from entry 0.
